// File: rtl/stopwatch_bcd_core.sv
// Two-digit BCD stopwatch: debounced start/stop and clear, run/pause FSM, tick prescaler.
// Button-to-state latency is DEBOUNCE_CYCLES+3 edges; digits advance one edge after a tick.
module stopwatch_bcd_core #(
  parameter int TICK_DIV        = 5_000_000,
  parameter int DEBOUNCE_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       rollover
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int PS_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  // bit 0 = start/stop, bit 1 = clear
  logic [1:0]      w_btn;
  logic [1:0]      r_meta;
  logic [1:0]      r_sync;
  logic [1:0]      r_stable;
  logic [1:0]      r_stable_d;
  logic [DB_W-1:0] r_db_cnt [2];
  logic [1:0]      w_press;

  logic [PS_W-1:0] r_presc;
  logic            w_tick;
  logic [3:0]      r_tens;
  logic [3:0]      r_ones;
  logic            r_rollover;

  assign w_btn = {btn_clear, btn_start_stop};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta     <= '0;
      r_sync     <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_meta     <= w_btn;
      r_sync     <= r_meta;
      r_stable_d <= r_stable;
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_stable[i] <= r_sync[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_press = r_stable & ~r_stable_d;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_press[1]) begin
      w_state_nxt = S_IDLE;
    end else if (w_press[0]) begin
      case (r_state)
        S_IDLE:   w_state_nxt = S_RUN;
        S_RUN:    w_state_nxt = S_PAUSED;
        S_PAUSED: w_state_nxt = S_RUN;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_tick = (r_presc == PS_W'(TICK_DIV - 1)) && (r_state == S_RUN);

  // Prescaler only moves in RUN, so a pause keeps the partial second.
  always_ff @(posedge clk) begin
    if (reset || w_press[1]) begin
      r_presc    <= '0;
      r_tens     <= 4'd0;
      r_ones     <= 4'd0;
      r_rollover <= 1'b0;
    end else begin
      r_rollover <= 1'b0;
      if (r_state == S_RUN) r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        if (r_ones != 4'd9) begin
          r_ones <= r_ones + 4'd1;
        end else begin
          r_ones <= 4'd0;
          if (r_tens == 4'd9) begin
            r_tens     <= 4'd0;
            r_rollover <= 1'b1;
          end else begin
            r_tens <= r_tens + 4'd1;
          end
        end
      end
    end
  end

  assign tens     = r_tens;
  assign ones     = r_ones;
  assign running  = (r_state == S_RUN);
  assign rollover = r_rollover;

endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// Directed bench for stopwatch_bcd_core with TICK_DIV=3, DEBOUNCE_CYCLES=4.
module tb_stopwatch_bcd_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start_stop;
  logic       btn_clear;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       rollover;

  int n_pass  = 0;
  int n_total = 0;

  stopwatch_bcd_core #(
    .TICK_DIV        (3),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .tens           (tens),
    .ones           (ones),
    .running        (running),
    .rollover       (rollover)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    btn_start_stop = 1'b0;
    btn_clear = 1'b0;

    // Reset held two cycles
    step(2);
    chk("rst_tens", 32'(tens), 0);
    chk("rst_ones", 32'(ones), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_rollover", 32'(rollover), 0);
    reset = 1'b0;

    // Start held: RUN after edge 7, then ones every 3 cycles
    btn_start_stop = 1'b1;
    step(6);  chk("start_edge6_running", 32'(running), 0);
    step(1);  chk("start_edge7_running", 32'(running), 1);
              chk("start_edge7_ones", 32'(ones), 0);
    step(3);  chk("run_edge10_ones", 32'(ones), 1);
    btn_start_stop = 1'b0;
    step(2);  chk("run_edge12_ones", 32'(ones), 1);
    step(1);  chk("run_edge13_ones", 32'(ones), 2);

    // Clear press while running
    btn_clear = 1'b1;
    step(6);  chk("clr_pre_running", 32'(running), 1);
              chk("clr_pre_ones", 32'(ones), 4);
    step(1);  chk("clr_running", 32'(running), 0);
              chk("clr_ones", 32'(ones), 0);
              chk("clr_tens", 32'(tens), 0);
    btn_clear = 1'b0;
    step(10);

    // 3-cycle glitch must not register
    btn_start_stop = 1'b1;
    step(3);
    btn_start_stop = 1'b0;
    step(12);
    chk("glitch_running", 32'(running), 0);
    chk("glitch_ones", 32'(ones), 0);

    // Count 00 -> 99 -> wrap
    btn_start_stop = 1'b1;
    step(7);   chk("wrap_start_running", 32'(running), 1);
    btn_start_stop = 1'b0;
    step(30);  chk("cnt10_tens", 32'(tens), 1);
               chk("cnt10_ones", 32'(ones), 0);
    step(267); chk("cnt99_tens", 32'(tens), 9);
               chk("cnt99_ones", 32'(ones), 9);
               chk("cnt99_rollover", 32'(rollover), 0);
    step(2);   chk("cnt99_hold_ones", 32'(ones), 9);
    step(1);   chk("wrap_tens", 32'(tens), 0);
               chk("wrap_ones", 32'(ones), 0);
               chk("wrap_rollover", 32'(rollover), 1);
    step(1);   chk("wrap_rollover_end", 32'(rollover), 0);
               chk("wrap_next_ones", 32'(ones), 0);
    step(2);   chk("after_wrap_ones", 32'(ones), 1);

    // Pause with prescaler one cycle in, then resume
    btn_start_stop = 1'b1;
    step(6);  chk("pause_pre_running", 32'(running), 1);
              chk("pause_pre_ones", 32'(ones), 3);
    step(1);  chk("pause_running", 32'(running), 0);
              chk("pause_ones", 32'(ones), 3);
    btn_start_stop = 1'b0;
    step(50); chk("paused50_ones", 32'(ones), 3);
              chk("paused50_running", 32'(running), 0);
    btn_start_stop = 1'b1;
    step(7);  chk("resume_running", 32'(running), 1);
              chk("resume_ones", 32'(ones), 3);
    btn_start_stop = 1'b0;
    step(1);  chk("resume_plus1_ones", 32'(ones), 3);
    step(1);  chk("resume_plus2_ones", 32'(ones), 4);

    // Start and clear pressed together at 37: clear wins
    step(94); chk("pre37_tens", 32'(tens), 3);
              chk("pre37_ones", 32'(ones), 5);
    btn_start_stop = 1'b1;
    btn_clear = 1'b1;
    step(6);  chk("at37_tens", 32'(tens), 3);
              chk("at37_ones", 32'(ones), 7);
              chk("at37_running", 32'(running), 1);
    step(1);  chk("both_running", 32'(running), 0);
              chk("both_tens", 32'(tens), 0);
              chk("both_ones", 32'(ones), 0);
              chk("both_rollover", 32'(rollover), 0);
    btn_start_stop = 1'b0;
    btn_clear = 1'b0;
    step(12); chk("both_release_running", 32'(running), 0);

    // Reset mid-debounce with the button still held
    btn_start_stop = 1'b1;
    step(3);
    reset = 1'b1;
    step(1);  chk("rst_mid_running", 32'(running), 0);
    reset = 1'b0;
    step(6);  chk("rst_held_edge6_running", 32'(running), 0);
    step(1);  chk("rst_held_edge7_running", 32'(running), 1);
    btn_start_stop = 1'b0;
    step(2);  chk("rst_held_ones_pre", 32'(ones), 0);
    step(1);  chk("rst_held_ones_tick", 32'(ones), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
